// File: rtl/apb_master_bridge.sv
// APB initiator: turns valid/ready register commands into single APB
// SETUP/ACCESS transfers, with a watchdog that aborts stuck transfers.
module apb_master_bridge #(
  parameter int BW      = 32,
  parameter int ADDR_W  = 16,
  parameter int DW      = 8,
  parameter int MAX_DIM = BW / DW,
  parameter int TIMEOUT = 16
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic               cmd_write_i,
  input  logic [ADDR_W-1:0]  cmd_addr_i,
  input  logic [BW-1:0]      cmd_wdata_i,
  input  logic [MAX_DIM-1:0] cmd_strb_i,
  output logic               rsp_valid_o,
  output logic [BW-1:0]      rsp_rdata_o,
  output logic               rsp_err_o,
  output logic               rsp_timeout_o,
  output logic               busy_o,
  output logic               psel_o,
  output logic               penable_o,
  output logic               pwrite_o,
  output logic [ADDR_W-1:0]  paddr_o,
  output logic [BW-1:0]      pwdata_o,
  output logic [MAX_DIM-1:0] pstrb_o,
  input  logic               pready_i,
  input  logic [BW-1:0]      prdata_i,
  input  logic               pslverr_i
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS
  } state_t;

  localparam logic [7:0] LP_LAST = 8'(TIMEOUT - 1);

  state_t               r_state;
  logic [7:0]           r_cnt;
  logic                 r_cmd_ready;
  logic                 r_busy;
  logic                 r_psel;
  logic                 r_penable;
  logic                 r_pwrite;
  logic [ADDR_W-1:0]    r_paddr;
  logic [BW-1:0]        r_pwdata;
  logic [MAX_DIM-1:0]   r_pstrb;
  logic                 r_rsp_valid;
  logic [BW-1:0]        r_rsp_rdata;
  logic                 r_rsp_err;
  logic                 r_rsp_timeout;
  logic                 w_done;

  // pready in the last watchdog cycle still counts as a normal completion
  assign w_done = pready_i || (r_cnt == LP_LAST);

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_cmd_ready   <= 1'b1;
      r_busy        <= 1'b0;
      r_psel        <= 1'b0;
      r_penable     <= 1'b0;
      r_pwrite      <= 1'b0;
      r_paddr       <= '0;
      r_pwdata      <= '0;
      r_pstrb       <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (cmd_valid_i && r_cmd_ready) begin
            r_state     <= S_SETUP;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_psel      <= 1'b1;
            r_paddr     <= cmd_addr_i;
            r_pwrite    <= cmd_write_i;
            r_pwdata    <= cmd_write_i ? cmd_wdata_i : '0;
            r_pstrb     <= cmd_write_i ? cmd_strb_i : '0;
          end
        end
        S_SETUP: begin
          r_state   <= S_ACCESS;
          r_penable <= 1'b1;
          r_cnt     <= '0;
        end
        S_ACCESS: begin
          if (w_done) begin
            r_state       <= S_IDLE;
            r_cmd_ready   <= 1'b1;
            r_busy        <= 1'b0;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_cnt         <= '0;
            r_rsp_valid   <= 1'b1;
            r_rsp_err     <= pready_i ? pslverr_i : 1'b1;
            r_rsp_timeout <= !pready_i;
            r_rsp_rdata   <= (pready_i && !r_pwrite) ? prdata_i : '0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready_o   = r_cmd_ready;
  assign busy_o        = r_busy;
  assign psel_o        = r_psel;
  assign penable_o     = r_penable;
  assign pwrite_o      = r_pwrite;
  assign paddr_o       = r_paddr;
  assign pwdata_o      = r_pwdata;
  assign pstrb_o       = r_pstrb;
  assign rsp_valid_o   = r_rsp_valid;
  assign rsp_rdata_o   = r_rsp_rdata;
  assign rsp_err_o     = r_rsp_err;
  assign rsp_timeout_o = r_rsp_timeout;

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- APB initiator that drives the matrix-multiplier APB slave (control, operand A/B, flags and scratchpad registers) from a simple valid/ready command interface.
- Used by the on-chip test sequencer and the host-side adapter to issue single register reads and writes.
- Converts each accepted command into one APB SETUP/ACCESS transfer, waits for pready, and returns a one-cycle response pulse carrying read data and error status.
- A watchdog aborts transfers that the slave never completes.

Parameters:
- BW, 32, APB data bus width (pwdata/prdata).
- ADDR_W, 16, APB address width.
- DW, 8, byte-lane width used for strobe granularity.
- MAX_DIM, BW/DW, number of strobe bits.
- TIMEOUT, 16, maximum ACCESS cycles without pready before abort; legal range 2..255.

Ports:
- clk_i  in  1  clock; all flops rise on posedge.
- reset_ni  in  1  asynchronous active-low reset.
- cmd_valid_i  in  1  command request.
- cmd_ready_o  out  1  bridge can accept a command; high only in IDLE.
- cmd_write_i  in  1  1 = write, 0 = read.
- cmd_addr_i  in  ADDR_W  target address.
- cmd_wdata_i  in  BW  write data.
- cmd_strb_i  in  MAX_DIM  write byte strobes.
- rsp_valid_o  out  1  one-cycle response pulse.
- rsp_rdata_o  out  BW  read data; 0 for writes and timeouts.
- rsp_err_o  out  1  pslverr sampled at completion, or timeout.
- rsp_timeout_o  out  1  response was produced by the watchdog.
- busy_o  out  1  transfer in progress (SETUP or ACCESS).
- psel_o  out  1  APB select.
- penable_o  out  1  APB enable.
- pwrite_o  out  1  APB direction.
- paddr_o  out  ADDR_W  APB address.
- pwdata_o  out  BW  APB write data.
- pstrb_o  out  MAX_DIM  APB strobes.
- pready_i  in  1  slave ready.
- prdata_i  in  BW  slave read data.
- pslverr_i  in  1  slave error.

Behaviour:
- Reset (async, reset_ni low):
  - State goes to IDLE.
  - All outputs go to 0, except cmd_ready_o, which goes to 1 once IDLE is reached.
  - Watchdog counter clears.
  - Reset mid-transfer drops psel/penable immediately and produces no response.
- States:
  - IDLE:
    - cmd_ready_o=1, psel=0, penable=0.
    - On cmd_valid_i&cmd_ready_o, capture cmd into paddr/pwrite/pwdata/pstrb registers and go to SETUP.
    - For reads, pstrb=0 and pwdata=0.
  - SETUP: psel=1, penable=0 for exactly one cycle, then go to ACCESS.
  - ACCESS:
    - psel=1, penable=1.
    - paddr, pwrite, pwdata and pstrb are held stable.
    - Watchdog counter increments each ACCESS cycle.
- Completion: in an ACCESS cycle with pready_i=1, on the next edge:
  - psel and penable drop to 0.
  - rsp_valid_o pulses for 1 cycle.
  - rsp_err_o = pslverr_i.
  - rsp_rdata_o = prdata_i if read, else 0.
  - rsp_timeout_o = 0.
  - State returns to IDLE.
- Timeout: if the counter reaches TIMEOUT with pready_i still 0:
  - Abort and return to IDLE.
  - rsp_valid_o=1, rsp_err_o=1, rsp_timeout_o=1, rsp_rdata_o=0.
  - pready_i arriving in that same cycle wins: it is treated as normal completion.
- Response outputs hold their values until the next response; only rsp_valid_o is a pulse.
- Minimum transfer length: SETUP + 1 ACCESS = 2 cycles. A new command is accepted in the response cycle at earliest, so there is a minimum of 1 idle cycle between transfers.
- Commands presented while not IDLE are ignored (cmd_ready_o=0); the requester must hold cmd_valid_i.
- busy_o = 1 in SETUP and ACCESS.
- All APB outputs are registered (no combinational path from cmd_* to p*).

Test Plan:
1. Write addr 0x0000, wdata 0x00000001, strb 0xF; slave pready 1 cycle after penable.
   - Required: psel 1 cycle before penable; rsp_valid one pulse with err=0, rdata=0; total 3 cycles from accept to rsp_valid.
2. Read addr 0x0004; slave returns prdata 0xDEADBEEF with pready after 2 wait states.
   - Required: rsp_rdata=0xDEADBEEF; pstrb=0 throughout; paddr stable through all ACCESS cycles.
3. Write addr 0x0008; slave asserts pready together with pslverr (busy slave).
   - Required: rsp_err=1, rsp_timeout=0, state back in IDLE.
4. Read with pready never asserted, TIMEOUT=16.
   - Required: exactly 16 ACCESS cycles, then rsp_valid with err=1, timeout=1, rdata=0; psel drops.
5. reset_ni pulled low during the 3rd ACCESS cycle.
   - Required: psel/penable/busy go to 0 asynchronously, no rsp_valid, cmd_ready=1 after release.
6. cmd_valid held high with 3 queued writes to 0x0004.
   - Required: exactly 3 transfers, each separated by 1 idle cycle, 3 rsp_valid pulses.
